// File: rtl/sram_like_resp.sv
// sram_like_resp: in-order SRAM-like responder, fixed-latency data_ok over a 2^AW word memory.
// Optional macro RANDOM_STALL_EN throttles addr_ok and response pops with a 16-bit LFSR.
module sram_like_resp #(
    parameter int DEPTH = 4,
    parameter int LAT   = 2,
    parameter int AW    = 14
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0]    CNT_INIT = 4'(LAT - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    // Handshake: a request is taken on any edge where req_i && addr_ok_o; data_ok_o is a
    // one-cycle pulse per accepted request, strictly in order, never backpressured.

    logic [31:0]   mem_q [2**AW];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    cnt_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   rdata_q;
    logic [AW-1:0] idx;
    logic          accept, pop, head_ready, acc_en, pop_en;
    logic          unused_ok;

    assign unused_ok = ^{size_i, addr_i[31:AW+2], addr_i[1:0]};

`ifdef RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign acc_en = lfsr_q[0];
    assign pop_en = lfsr_q[1];

    always_ff @(posedge clk) begin
        if (!resetn) lfsr_q <= 16'hACE1;
        else         lfsr_q <= lfsr_d;
    end
`else
    assign acc_en = 1'b1;
    assign pop_en = 1'b1;
`endif

    assign idx        = addr_i[AW+1:2];
    assign head_ready = (count_q != '0) && (cnt_q[rp_q] == 4'd0);
    assign addr_ok_o  = resetn & req_i & (count_q < FULL) & acc_en;
    assign accept     = req_i & addr_ok_o;
    assign pop        = resetn & head_ready & pop_en;
    assign data_ok_o  = pop;
    // rdata presents the head word on a pop and otherwise repeats the last response.
    assign rdata_o    = pop ? data_q[rp_q] : rdata_q;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (accept) wp_d = wp_q + PW'(1);
        if (pop)    rp_d = rp_q + PW'(1);
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            rdata_q <= rdata_o;
        end
    end

    // Countdowns saturate at zero, so a head held back by a stall stays ready.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_q[i] != 4'd0) cnt_q[i] <= cnt_q[i] - 4'd1;
            end
            if (accept) begin
                cnt_q[wp_q]  <= CNT_INIT;
                data_q[wp_q] <= wr_i ? 32'h0 : mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && wr_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: two instances (LAT=2 and LAT=8) checked every cycle against a
// queue-based response model; builds with or without RANDOM_STALL_EN.
module tb_sram_like_resp;
    localparam int DEPTH = 4;
    localparam int AW    = 14;
    localparam int NW    = 1 << AW;
    localparam int LAT0  = 2;
    localparam int LAT1  = 8;

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
    } ent_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic [1:0]       req, wr, addr_ok, data_ok;
    logic [1:0][1:0]  size;
    logic [1:0][3:0]  wstrb;
    logic [1:0][31:0] addr, wdata, rdata;
    logic             aok0, aok1, dok0, dok1;
    logic [31:0]      rd0, rd1;

    always #5 clk = ~clk;

    sram_like_resp #(.DEPTH(DEPTH), .LAT(LAT0), .AW(AW)) u_dut (
        .clk(clk), .resetn(resetn), .req_i(req[0]), .wr_i(wr[0]), .size_i(size[0]),
        .wstrb_i(wstrb[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .addr_ok_o(aok0), .data_ok_o(dok0), .rdata_o(rd0));

    sram_like_resp #(.DEPTH(DEPTH), .LAT(LAT1), .AW(AW)) u_full (
        .clk(clk), .resetn(resetn), .req_i(req[1]), .wr_i(wr[1]), .size_i(size[1]),
        .wstrb_i(wstrb[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .addr_ok_o(aok1), .data_ok_o(dok1), .rdata_o(rd1));

    assign addr_ok = {aok1, aok0};
    assign data_ok = {dok1, dok0};
    assign rdata   = {rd1, rd0};

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          check_en = 1'b0;
    ent_t        pend_q[$];
    logic [31:0] mem_m [2][NW];
    logic [31:0] last_rd [2];
    int          ok_cnt [2];
    int          last_ok_cyc [2];
    int          last_acc_cyc [2];
    logic [31:0] last_ok_data [2];
    logic [31:0] okd0_q[$];
    logic [31:0] okd1_q[$];
    int          okc1_q[$];
    int          acc1_q[$];
    int          stall_acc = 0;
    int          stall_pop = 0;
    int          acc_off [6] = '{0, 1, 2, 3, 9, 10};
    int          ok_off [6]  = '{8, 9, 10, 11, 17, 18};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int pend_count(input int i);
        int n = 0;
        foreach (pend_q[k]) if (pend_q[k].inst == i) n++;
        return n;
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                int            hidx;
                int            npend;
                bit            due;
                bit            exp_aok;
                logic [AW-1:0] widx;
                ent_t          e;
                hidx  = -1;
                npend = 0;
                for (int k = 0; k < pend_q.size(); k++) begin
                    if (pend_q[k].inst == i) begin
                        if (hidx < 0) hidx = k;
                        npend++;
                    end
                end
                due = 1'b0;
                if (resetn && hidx >= 0) due = (cyc >= pend_q[hidx].due);
                exp_aok = resetn && req[i] && (npend < DEPTH);
                check("outstanding_le_depth", 32'(npend <= DEPTH), 32'd1);
`ifdef RANDOM_STALL_EN
                check("addr_ok_gate", 32'(addr_ok[i] & ~exp_aok), 32'd0);
                check("data_ok_gate", 32'(data_ok[i] & ~due), 32'd0);
                if (exp_aok && !addr_ok[i]) stall_acc++;
                if (due && !data_ok[i]) stall_pop++;
`else
                check("addr_ok", 32'(addr_ok[i]), 32'(exp_aok));
                check("data_ok", 32'(data_ok[i]), 32'(due));
`endif
                if (data_ok[i] && hidx >= 0) begin
                    check("rdata", rdata[i], pend_q[hidx].data);
                    last_rd[i]      = pend_q[hidx].data;
                    ok_cnt[i]++;
                    last_ok_cyc[i]  = cyc;
                    last_ok_data[i] = rdata[i];
                    if (i == 0) okd0_q.push_back(rdata[i]);
                    else begin
                        okd1_q.push_back(rdata[i]);
                        okc1_q.push_back(cyc);
                    end
                    pend_q.delete(hidx);
                end else if (!data_ok[i]) begin
                    check("rdata_hold", rdata[i], last_rd[i]);
                end
                if (req[i] && addr_ok[i]) begin
                    widx   = addr[i][AW+1:2];
                    e.inst = i;
                    e.due  = cyc + lat_of(i);
                    e.data = wr[i] ? 32'h0 : mem_m[i][widx];
                    if (wr[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (wstrb[i][b]) mem_m[i][widx][8*b +: 8] = wdata[i][8*b +: 8];
                    end
                    pend_q.push_back(e);
                    last_acc_cyc[i] = cyc;
                    if (i == 1) acc1_q.push_back(cyc);
                end
            end
            if (!resetn) begin
                pend_q.delete();
                last_rd[0] = 32'h0;
                last_rd[1] = 32'h0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int i, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int guard;
        bit got;
        guard    = 0;
        req[i]   = 1'b1;
        wr[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        wstrb[i] = s;
        size[i]  = 2'($urandom_range(0, 2));
        do begin
            @(negedge clk);
            got = addr_ok[i];
            @(posedge clk);
            #1;
            guard++;
        end while (!got && guard < 200);
        check("send_accepted", 32'(got), 32'd1);
        req[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int g;
        g = 0;
        while (pend_count(i) > 0 && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_done", 32'(pend_count(i)), 32'd0);
    endtask

    task automatic random_ops(input int i, input int n, input int words);
        bit          w;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            w = 1'($urandom_range(0, 1));
            a = {16'($urandom()), 14'($urandom_range(0, words - 1)), 2'($urandom_range(0, 3))};
            send(i, w, a, $urandom(), 4'($urandom_range(0, 15)));
            idle($urandom_range(0, 2));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        int ok1;
        for (int i = 0; i < 2; i++) begin
            last_rd[i]      = 32'h0;
            ok_cnt[i]       = 0;
            last_ok_cyc[i]  = 0;
            last_acc_cyc[i] = 0;
            last_ok_data[i] = 32'h0;
        end
        resetn = 1'b0;
        req    = '0;
        wr     = '0;
        size   = '0;
        wstrb  = '0;
        addr   = '0;
        wdata  = '0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        req      = 2'b11;
        @(negedge clk);
        check("reset_addr_ok", 32'(addr_ok), 32'd0);
        check("reset_data_ok", 32'(data_ok), 32'd0);
        check("reset_rdata0", rdata[0], 32'h0);
        check("reset_rdata1", rdata[1], 32'h0);
        @(posedge clk);
        #1;
        req    = '0;
        resetn = 1'b1;
        idle(2);

        for (int k = 0; k < 48; k++) send(0, 1'b1, 32'(k * 4), $urandom(), 4'hF);
        drain(0);
        for (int k = 0; k < 8; k++) send(1, 1'b1, 32'(k * 4), 32'hF00D0000 + 32'(k), 4'hF);
        drain(1);

        // read latency
        send(0, 1'b1, 32'h14, 32'h12345678, 4'hF);
        drain(0);
        a0 = ok_cnt[0];
        send(0, 1'b0, 32'h14, 32'h0, 4'h0);
        drain(0);
        idle(2);
        check("lat_ok_count", 32'(ok_cnt[0] - a0), 32'd1);
`ifndef RANDOM_STALL_EN
        check("lat_cycles", 32'(last_ok_cyc[0] - last_acc_cyc[0]), 32'd2);
`endif
        check("lat_rdata", last_ok_data[0], 32'h12345678);

        // byte-strobe write
        send(0, 1'b1, 32'h20, 32'h0, 4'hF);
        send(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        a0 = last_acc_cyc[0];
        drain(0);
`ifndef RANDOM_STALL_EN
        check("wr_lat", 32'(last_ok_cyc[0] - a0), 32'd2);
`endif
        check("wr_rdata_zero", last_ok_data[0], 32'h0);
        send(0, 1'b0, 32'h20, 32'h0, 4'h0);
        drain(0);
        check("strobe_rdata", last_ok_data[0], 32'h00BB00DD);

        // pointer wrap
        for (int k = 0; k < 10; k++) send(0, 1'b1, 32'(k * 4), 32'(k), 4'hF);
        drain(0);
        okd0_q.delete();
        for (int k = 0; k < 10; k++) send(0, 1'b0, 32'(k * 4), 32'h0, 4'h0);
        drain(0);
        check("wrap_count", 32'(okd0_q.size()), 32'd10);
        for (int k = 0; k < 10; k++)
            if (k < okd0_q.size()) check("wrap_data", okd0_q[k], 32'(k));

        // full queue on the LAT=8 instance
        acc1_q.delete();
        okc1_q.delete();
        okd1_q.delete();
        for (int k = 0; k < 6; k++) send(1, 1'b0, 32'(k * 4), 32'h0, 4'h0);
        drain(1);
        check("full_ok_count", 32'(okd1_q.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < okd1_q.size()) check("full_order", okd1_q[k], 32'hF00D0000 + 32'(k));
`ifndef RANDOM_STALL_EN
        for (int k = 0; k < 6; k++) begin
            if (k < acc1_q.size()) check("full_acc_time", 32'(acc1_q[k] - acc1_q[0]), 32'(acc_off[k]));
            if (k < okc1_q.size()) check("full_ok_time", 32'(okc1_q[k] - acc1_q[0]), 32'(ok_off[k]));
        end
`endif

        // reset mid-operation
        for (int k = 0; k < 3; k++) send(1, 1'b0, 32'((k + 1) * 4), 32'h0, 4'h0);
        ok1    = ok_cnt[1];
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(12);
        check("reset_drop", 32'(ok_cnt[1] - ok1), 32'd0);
        send(1, 1'b0, 32'h8000000C, 32'h0, 4'h0);
        a0 = last_acc_cyc[1];
        drain(1);
`ifndef RANDOM_STALL_EN
        check("post_reset_lat", 32'(last_ok_cyc[1] - a0), 32'd8);
`endif
        check("post_reset_rdata", last_ok_data[1], 32'hF00D0003);

        // random traffic on both instances
        fork
            random_ops(0, 200, 48);
            random_ops(1, 60, 8);
        join
        drain(0);
        drain(1);
        idle(3);
`ifdef RANDOM_STALL_EN
        check("stall_addr_seen", 32'(stall_acc > 0), 32'd1);
        check("stall_pop_seen", 32'(stall_pop > 0), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
